// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture gate.
package adc_capture_pkg;

    localparam int ADC_BEAT_SAMPLES = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        CAPTURE,
        DONE
    } cap_state_t;

endpackage

// File: rtl/adc_delay_ring.sv
// Pretrigger delay line: a PRE_DEPTH-entry ring written every valid beat.
// The beat read out is the one written PRE_DEPTH valid beats earlier.
module adc_delay_ring #(
    parameter int ADC_WIDTH = 128,
    parameter int PRE_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [ADC_WIDTH-1:0] wr_data,
    output logic [ADC_WIDTH-1:0] rd_data
);

    localparam int AW = (PRE_DEPTH > 1) ? $clog2(PRE_DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(PRE_DEPTH - 1);

    (* ram_style = "distributed" *) logic [ADC_WIDTH-1:0] mem [PRE_DEPTH];
    logic [AW-1:0] wp;

    // Ring write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem[wp] <= wr_data;
        end
    end

    // Read-before-write output register and wrapping write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rd_data <= '0;
        end else if (ce) begin
            rd_data <= mem[wp];
            wp      <= (wp == LAST) ? '0 : wp + 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_gate.sv
// Pretrigger capture gate between an RFDC ADC stream and a readout buffer.
// After arm + trigger, forwards capture_len beats starting PRE_DEPTH beats
// before the trigger beat. Never backpressures the ADC.
module adc_capture_gate
    import adc_capture_pkg::*;
#(
    parameter int ADC_WIDTH = 128,
    parameter int PRE_DEPTH = 16,
    parameter int LEN_BITS  = 16
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic [ADC_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [ADC_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic                 arm,
    input  logic                 trigger,
    input  logic [LEN_BITS-1:0]  capture_len,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int FW = (PRE_DEPTH > 1) ? $clog2(PRE_DEPTH) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(PRE_DEPTH - 1);

    cap_state_t          state;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] emit_cnt;   // beats still to emit after the current one
    logic [FW-1:0]       fill_cnt;
    logic                arm_ok;

    assign s_axis_tready = 1'b1;
    assign arm_ok        = arm && (capture_len != '0);

    adc_delay_ring #(
        .ADC_WIDTH (ADC_WIDTH),
        .PRE_DEPTH (PRE_DEPTH)
    ) u_ring (
        .clk     (aclk),
        .rst     (arst),
        .ce      (s_axis_tvalid),
        .wr_data (s_axis_tdata),
        .rd_data (m_axis_tdata)
    );

    // Capture FSM with registered strobe and status outputs. A zero-length
    // arm is ignored everywhere; an accepted arm always restarts FILL and
    // takes priority over a same-cycle trigger or emission.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state         <= IDLE;
            len_q         <= '0;
            emit_cnt      <= '0;
            fill_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            m_axis_tvalid <= 1'b0;
            if (m_axis_tvalid && !m_axis_tready) begin
                overflow <= 1'b1;
            end
            if (arm_ok) begin
                state    <= FILL;
                len_q    <= capture_len;
                fill_cnt <= '0;
                overflow <= 1'b0;
                busy     <= 1'b1;
                done     <= 1'b0;
            end else begin
                case (state)
                    FILL: begin
                        if (s_axis_tvalid) begin
                            if (fill_cnt == FILL_LAST) begin
                                state <= ARMED;
                            end else begin
                                fill_cnt <= fill_cnt + 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (s_axis_tvalid && trigger) begin
                            m_axis_tvalid <= 1'b1;
                            emit_cnt      <= len_q - 1'b1;
                            if (len_q == LEN_BITS'(1)) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (s_axis_tvalid) begin
                            m_axis_tvalid <= 1'b1;
                            emit_cnt      <= emit_cnt - 1'b1;
                            if (emit_cnt == LEN_BITS'(1)) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_gate.sv
// Directed bench for adc_capture_gate with a queue-based reference model.
module tb_adc_capture_gate;
    import adc_capture_pkg::*;

    localparam int P = 4;

    logic         aclk = 1'b0;
    logic         arst = 1'b1;
    logic [127:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         arm = 1'b0;
    logic         trigger = 1'b0;
    logic [15:0]  capture_len = '0;
    logic         busy, done, overflow;

    adc_capture_gate #(.ADC_WIDTH(128), .PRE_DEPTH(P), .LEN_BITS(16)) dut (
        .aclk(aclk), .arst(arst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .arm(arm), .trigger(trigger), .capture_len(capture_len),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int nbeat = 0;
    int cyc_cnt = 0;
    bit chk_en = 1'b0;
    bit rdy_cfg = 1'b1;
    bit rst_cfg = 1'b1;
    int log_val[$];
    int log_cyc[$];

    // Model state: expected outputs after each edge.
    bit           exp_vld = 0, exp_busy = 0, exp_done = 0, exp_ovf = 0;
    logic [127:0] exp_data = '0;
    logic [127:0] dq[$];
    bit           active = 0, trig_seen = 0;
    int           since = 0, left = 0, mlen = 0;

    function automatic logic [127:0] ramp(input int n);
        logic [127:0] r;
        logic [15:0]  s;
        s = 16'(n);
        r = '0;
        for (int i = 0; i < ADC_BEAT_SAMPLES; i++) r[i*16 +: 16] = s;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc_cnt);
        end
    endtask

    // Drive one cycle of inputs at the falling edge.
    task automatic cyc(input bit v, input bit t, input bit a, input int len);
        @(negedge aclk);
        arst          = rst_cfg;
        m_axis_tready = rdy_cfg;
        s_axis_tvalid = v;
        trigger       = t;
        arm           = a;
        capture_len   = 16'(len);
        s_axis_tdata  = v ? ramp(nbeat) : '0;
        if (v) nbeat++;
    endtask

    task automatic beats_until(input int b);
        while (nbeat < b) cyc(1, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic chk_seq(input string nm, input int first, input int n);
        chk({nm, "_count"}, 128'(log_val.size()), 128'(n));
        for (int i = 0; i < n; i++)
            chk({nm, "_val"}, 128'((i < log_val.size()) ? log_val[i] : -1), 128'(first + i));
    endtask

    // Reference model: arm, count P post-arm beats, then emit len beats from
    // the trigger onward, each carrying the input seen P valid beats earlier.
    always @(posedge aclk) begin
        bit           emit;
        logic [127:0] old;
        emit = 0;
        old  = (dq.size() == P) ? dq[0] : 'x;
        if (arst) begin
            active = 0; trig_seen = 0; exp_busy = 0; exp_done = 0; exp_ovf = 0;
            exp_vld = 0; exp_data = '0;
            dq.delete();
        end else begin
            if (arm && capture_len != 0) begin
                active = 1; trig_seen = 0; since = 0; mlen = capture_len;
                exp_ovf = 0; exp_busy = 1; exp_done = 0;
            end else begin
                if (exp_vld && !m_axis_tready) exp_ovf = 1;
                if (active && s_axis_tvalid) begin
                    if (since < P) since++;
                    else begin
                        if (!trig_seen && trigger) begin trig_seen = 1; left = mlen; end
                        if (trig_seen) begin
                            emit = 1;
                            left--;
                            if (left == 0) begin active = 0; exp_busy = 0; exp_done = 1; end
                        end
                    end
                end
            end
            exp_vld = emit;
            if (emit) exp_data = old;
            if (s_axis_tvalid) begin
                dq.push_back(s_axis_tdata);
                if (dq.size() > P) void'(dq.pop_front());
            end
        end
    end

    // Per-cycle comparison against the model, plus an emitted-beat log.
    always @(negedge aclk) begin
        if (chk_en) begin
            cyc_cnt++;
            chk("tvalid", 128'(m_axis_tvalid), 128'(exp_vld));
            if (exp_vld && m_axis_tvalid) chk("tdata", m_axis_tdata, exp_data);
            chk("busy", 128'(busy), 128'(exp_busy));
            chk("done", 128'(done), 128'(exp_done));
            chk("overflow", 128'(overflow), 128'(exp_ovf));
            if (m_axis_tvalid === 1'b1) begin
                log_val.push_back(int'(m_axis_tdata[15:0]));
                log_cyc.push_back(cyc_cnt);
            end
        end
    end

    initial begin
        bit ok;
        // Reset
        rst_cfg = 1;
        idle(3);
        rst_cfg = 0;
        idle(1);
        chk_en = 1;
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_tdata", m_axis_tdata, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("tready_tied", 128'(s_axis_tready), 128'(1));

        // Basic capture: len 8, trigger on beat 100
        nbeat = 0;
        beats_until(10);
        cyc(1, 0, 1, 8);
        cyc(1, 0, 0, 0);
        chk("busy_after_arm", 128'(busy), 128'(1));
        beats_until(100);
        log_val.delete(); log_cyc.delete();
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
        chk_seq("basic", 96, 8);
        ok = (log_cyc.size() == 8);
        for (int i = 1; i < log_cyc.size(); i++) if (log_cyc[i] != log_cyc[i-1] + 1) ok = 0;
        chk("basic_consecutive", 128'(ok), 128'(1));
        chk("basic_done", 128'(done), 128'(1));
        chk("basic_busy", 128'(busy), 128'(0));

        // Early trigger in FILL, trigger without valid, gapped capture at 50
        nbeat = 40;
        log_val.delete(); log_cyc.delete();
        cyc(1, 0, 1, 8);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        beats_until(48);
        cyc(0, 1, 0, 0);
        beats_until(50);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); end
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
        chk_seq("gapped", 46, 8);
        ok = (log_cyc.size() == 8);
        for (int i = 1; i < log_cyc.size(); i++) if (log_cyc[i] != log_cyc[i-1] + 2) ok = 0;
        chk("gapped_spacing", 128'(ok), 128'(1));

        // Zero-length arm ignored, then re-arm after the first emitted beat
        nbeat = 200;
        log_val.delete(); log_cyc.delete();
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("zero_len_busy", 128'(busy), 128'(0));
        chk("zero_len_done", 128'(done), 128'(1));
        cyc(1, 0, 1, 3);
        beats_until(208);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 5);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_seq("rearm", 204, 1);
        chk("rearm_busy", 128'(busy), 128'(1));
        chk("rearm_done", 128'(done), 128'(0));
        chk("rearm_ovf", 128'(overflow), 128'(0));

        // Overflow on the third emitted beat
        nbeat = 300;
        log_val.delete(); log_cyc.delete();
        cyc(1, 0, 1, 5);
        beats_until(310);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        rdy_cfg = 0;
        cyc(1, 0, 0, 0);
        rdy_cfg = 1;
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        chk_seq("ovf", 306, 5);
        chk("ovf_sticky", 128'(overflow), 128'(1));
        chk("ovf_done", 128'(done), 128'(1));
        cyc(1, 0, 1, 4);
        cyc(1, 0, 0, 0);
        chk("ovf_cleared", 128'(overflow), 128'(0));

        // Reset mid-capture
        nbeat = 400;
        log_val.delete(); log_cyc.delete();
        cyc(1, 0, 1, 8);
        beats_until(410);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        rst_cfg = 1;
        cyc(1, 0, 0, 0);
        rst_cfg = 0;
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk_seq("reset", 406, 3);
        chk("reset_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));

        // Long capture wrapping the ring many times
        nbeat = 1000;
        log_val.delete(); log_cyc.delete();
        cyc(1, 0, 1, 1000);
        beats_until(1010);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 1005; i++) cyc(1, 0, 0, 0);
        chk("wrap_count", 128'(log_val.size()), 128'(1000));
        ok = (log_val.size() == 1000);
        for (int i = 0; i < log_val.size(); i++) begin
            if (log_val[i] != 1006 + i) ok = 0;
            if (i > 0 && log_cyc[i] != log_cyc[i-1] + 1) ok = 0;
        end
        chk("wrap_contiguous", 128'(ok), 128'(1));
        chk("wrap_done", 128'(done), 128'(1));

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
